dmem_arbiter: RTL and testbench

Shares the single-port data memory between the pipeline's memory-stage access (LW/SW) and an external DMA/loader port. The CPU has priority when the arbiter is idle. A DMA master, once granted, keeps the port for a burst. The burst is bounded by a beat limit and by a CPU-starvation limit. The arbiter sits between the M stage and the DataMemory instance and drives a stall request back to the pipeline.

---
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the M-stage LW/SW port and a bursting DMA/loader port.
// Optional statistics counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BURST_MAX    = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_last,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       stat_cpu_stall,
  output logic [31:0]       stat_dma_beats
);

  localparam int unsigned BEAT_W   = $clog2(BURST_MAX + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 2);

  typedef enum logic {S_IDLE, S_DMA_BURST} state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                cpu_gnt;

  // Grant: CPU wins in IDLE; an owning DMA keeps the port until the CPU has starved long enough.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req)      cpu_gnt = 1'b1;
        else if (dma_req) dma_gnt = 1'b1;
      end
      S_DMA_BURST: begin
        if (dma_req && (starve_cnt_q < STARVE_W'(STARVE_LIMIT))) dma_gnt = 1'b1;
        else if (cpu_req)                                        cpu_gnt = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_write = cpu_we;
    end else if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_write = dma_we;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = cpu_req && !cpu_gnt;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

  // Ownership and counters; any non-DMA cycle inside a burst hands the port back to IDLE.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    dma_rvalid_d = dma_gnt && !dma_we;
    dma_rdata_d  = dma_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        beat_cnt_d = '0;
        if (dma_gnt && !dma_last && (BURST_MAX > 1)) begin
          state_d    = S_DMA_BURST;
          beat_cnt_d = BEAT_W'(1);
        end
      end
      S_DMA_BURST: begin
        if (dma_gnt && !dma_last && (beat_cnt_q != BEAT_W'(BURST_MAX - 1))) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end else begin
          state_d    = S_IDLE;
          beat_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        beat_cnt_d = '0;
      end
    endcase

    if (!cpu_req || cpu_gnt)                          starve_cnt_d = '0;
    else if (starve_cnt_q < STARVE_W'(STARVE_LIMIT))  starve_cnt_d = starve_cnt_q + STARVE_W'(1);

    if (dma_gnt && !dma_we) dma_rdata_d = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      beat_cnt_q   <= '0;
      starve_cnt_q <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_cpu_stall_q, stat_cpu_stall_d;
  logic [31:0] stat_dma_beats_q, stat_dma_beats_d;

  // Saturating event counters.
  always_comb begin
    stat_cpu_stall_d = stat_cpu_stall_q;
    stat_dma_beats_d = stat_dma_beats_q;
    if (cpu_stall && (stat_cpu_stall_q != '1)) stat_cpu_stall_d = stat_cpu_stall_q + 32'd1;
    if (dma_gnt && (stat_dma_beats_q != '1))   stat_dma_beats_d = stat_dma_beats_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cpu_stall_q <= '0;
      stat_dma_beats_q <= '0;
    end else begin
      stat_cpu_stall_q <= stat_cpu_stall_d;
      stat_dma_beats_q <= stat_dma_beats_d;
    end
  end

  assign stat_cpu_stall = stat_cpu_stall_q;
  assign stat_dma_beats = stat_dma_beats_q;
`else
  assign stat_cpu_stall = '0;
  assign stat_dma_beats = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_last;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_gnt, dma_rvalid, mem_write;
  logic [31:0] stat_cpu_stall, stat_dma_beats;
  logic [31:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

`ifdef DMEM_ARB_STATS_EN
  localparam logic [31:0] EXP_STALLS = 32'd7;
  localparam logic [31:0] EXP_BEATS  = 32'd19;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0;
  localparam logic [31:0] EXP_BEATS  = 32'd0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:2]];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .stat_cpu_stall(stat_cpu_stall), .stat_dma_beats(stat_dma_beats)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic drv_cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drv_dma(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic l);
    dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d; dma_last = l;
  endtask

  initial begin
    int  k;
    logic eg, es, cr;

    rst = 1'b0;
    drv_cpu(0, 0, 0, 0);
    drv_dma(0, 0, 0, 0, 0);
    #3;
    chk("rst_rvalid", 32'(dma_rvalid), 0);
    chk("rst_rdata", dma_rdata, 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_dma_gnt", 32'(dma_gnt), 0);
    cyc(); cyc();
    rst = 1'b1;

    // CPU only
    cyc(); drv_cpu(1, 1, 32'h10, 32'hDEADBEEF); settle();
    chk("cpu_sw_write", 32'(mem_write), 1);
    chk("cpu_sw_addr", mem_addr, 32'h10);
    chk("cpu_sw_data", mem_wdata, 32'hDEADBEEF);
    chk("cpu_sw_stall", 32'(cpu_stall), 0);
    cyc(); drv_cpu(1, 0, 32'h10, 0); settle();
    chk("cpu_lw_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("cpu_lw_write", 32'(mem_write), 0);
    cyc(); drv_cpu(1, 1, 32'h20, 32'h1234); settle();
    chk("cpu_sw20_write", 32'(mem_write), 1);
    cyc(); drv_cpu(0, 0, 0, 0); settle();
    chk("cpu_idle_write", 32'(mem_write), 0);

    // DMA only: 3-beat write burst
    for (int b = 0; b < 3; b++) begin
      cyc(); drv_dma(1, 1, 32'h100 + 32'(4 * b), 32'hA0 + 32'(b), b == 2); settle();
      chk("dma3_gnt", 32'(dma_gnt), 1);
      chk("dma3_addr", mem_addr, 32'h100 + 32'(4 * b));
      chk("dma3_write", 32'(mem_write), 1);
    end
    for (int b = 0; b < 3; b++) begin
      cyc(); drv_dma(0, 0, 0, 0, 0); drv_cpu(1, 0, 32'h100 + 32'(4 * b), 0); settle();
      chk("dma3_mem", cpu_rdata, 32'hA0 + 32'(b));
      chk("dma3_cpu_stall", 32'(cpu_stall), 0);
      chk("dma3_rvalid", 32'(dma_rvalid), 0);
    end

    // 20-beat burst, CPU waiting from beat 6: beat limit ends ownership after 8
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      eg = (c != 9);
      es = (c >= 6 && c <= 8);
      cr = (c >= 6 && c <= 9);
      cyc(); drv_dma(1, 1, 32'h200 + 32'(4 * k), 32'(k), 0); drv_cpu(cr, 0, 32'h10, 0); settle();
      chk($sformatf("lb_gnt_c%0d", c), 32'(dma_gnt), 32'(eg));
      chk($sformatf("lb_stall_c%0d", c), 32'(cpu_stall), 32'(es));
      if (eg) begin
        chk($sformatf("lb_addr_c%0d", c), mem_addr, 32'h200 + 32'(4 * k));
        k++;
      end else begin
        chk("lb_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      end
    end
    cyc(); drv_dma(0, 0, 0, 0, 0); drv_cpu(0, 0, 0, 0); settle();
    chk("lb_end_gnt", 32'(dma_gnt), 0);

    // Starvation: CPU arrives at beat 2, stalls 4 cycles, granted on the 5th
    k = 0;
    for (int c = 1; c <= 7; c++) begin
      eg = (c != 6);
      es = (c >= 2 && c <= 5);
      cr = (c >= 2 && c <= 6);
      cyc(); drv_dma(1, 1, 32'h300 + 32'(4 * k), 32'(k), 0); drv_cpu(cr, 0, 32'h10, 0); settle();
      chk($sformatf("sv_gnt_c%0d", c), 32'(dma_gnt), 32'(eg));
      chk($sformatf("sv_stall_c%0d", c), 32'(cpu_stall), 32'(es));
      if (eg) begin
        chk($sformatf("sv_addr_c%0d", c), mem_addr, 32'h300 + 32'(4 * k));
        k++;
      end
    end
    cyc(); drv_dma(0, 0, 0, 0, 0); drv_cpu(0, 0, 0, 0); settle();
    chk("sv_end_gnt", 32'(dma_gnt), 0);

    // Simultaneous CPU LW and DMA read of 0x20
    cyc(); drv_cpu(1, 0, 32'h20, 0); drv_dma(1, 0, 32'h20, 0, 1); settle();
    chk("sim_cpu_stall", 32'(cpu_stall), 0);
    chk("sim_dma_gnt0", 32'(dma_gnt), 0);
    chk("sim_cpu_rdata", cpu_rdata, 32'h1234);
    cyc(); drv_cpu(0, 0, 0, 0); settle();
    chk("sim_dma_gnt1", 32'(dma_gnt), 1);
    chk("sim_mem_addr", mem_addr, 32'h20);
    chk("sim_rvalid0", 32'(dma_rvalid), 0);
    cyc(); drv_dma(0, 0, 0, 0, 0); settle();
    chk("sim_rvalid1", 32'(dma_rvalid), 1);
    chk("sim_rdata", dma_rdata, 32'h1234);
    cyc(); settle();
    chk("sim_rvalid2", 32'(dma_rvalid), 0);
    chk("sim_rdata_hold", dma_rdata, 32'h1234);

    chk("stat_stall", stat_cpu_stall, EXP_STALLS);
    chk("stat_beats", stat_dma_beats, EXP_BEATS);

    // Reset mid-burst at beat 3 with a CPU load pending
    for (int b = 0; b < 2; b++) begin
      cyc(); drv_dma(1, 1, 32'h400 + 32'(4 * b), 32'hB0 + 32'(b), 0); settle();
      chk("rb_gnt", 32'(dma_gnt), 1);
    end
    cyc(); rst = 1'b0; drv_cpu(1, 0, 32'h10, 0);
    drv_dma(1, 1, 32'h408, 32'hB2, 0); settle();
    chk("rb_dma_gnt", 32'(dma_gnt), 0);
    chk("rb_cpu_stall", 32'(cpu_stall), 0);
    chk("rb_rvalid", 32'(dma_rvalid), 0);
    chk("rb_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("rb_stat_stall", stat_cpu_stall, 0);
    chk("rb_stat_beats", stat_dma_beats, 0);
    cyc(); rst = 1'b1; settle();
    chk("rb_idle_cpu_stall", 32'(cpu_stall), 0);
    chk("rb_idle_dma_gnt", 32'(dma_gnt), 0);
    cyc(); drv_cpu(0, 0, 0, 0); settle();
    chk("rb_regnt", 32'(dma_gnt), 1);
    chk("rb_regnt_addr", mem_addr, 32'h408);
    cyc(); drv_dma(0, 0, 0, 0, 0); settle();
    chk("rb_end_gnt", 32'(dma_gnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
